// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// Architectural register file for the MIPS decode stage. It has one write
// port and two independent combinational read ports (rs / rt). Entry 0 is
// hardwired to zero.
//
// When the bypass parameter is set, a write in the current cycle is forwarded
// to any read port addressing the same entry in that same cycle.
//
// Parameters
//   width       data width of each entry
//   depth       number of entries (entry 0 always reads 0)
//   addr_width  address width, 2**addr_width >= depth
//   bypass      1: forward same-cycle write data to reads, 0: stored value only
//
// Ports
//   Clock        in   rising-edge clock
//   Reset        in   synchronous active-high, clears every entry
//   WriteEnable  in   commit WriteData to WriteAddr at the next rising edge
//   WriteAddr    in   destination entry
//   WriteData    in   value to write
//   ReadAddr1    in   read port 1 address (rs)
//   ReadData1    out  read port 1 data, combinational
//   ReadAddr2    in   read port 2 address (rt)
//   ReadData2    out  read port 2 data, combinational
// -----------------------------------------------------------------------------
module register_file #(
    parameter int width      = 32,
    parameter int depth      = 32,
    parameter int addr_width = 5,
    parameter int bypass     = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  WriteEnable,
    input  logic [addr_width-1:0] WriteAddr,
    input  logic [width-1:0]      WriteData,
    input  logic [addr_width-1:0] ReadAddr1,
    output logic [width-1:0]      ReadData1,
    input  logic [addr_width-1:0] ReadAddr2,
    output logic [width-1:0]      ReadData2
);

    // One extra bit so that depth == 2**addr_width still fits in the limit.
    localparam logic [addr_width:0] depth_lim = (addr_width + 1)'(depth);

    logic [width-1:0] mem [depth];

    logic write_hit;
    logic read1_valid;
    logic read2_valid;

    // An address is usable only if it is not $zero and falls inside the array.
    function automatic logic addr_usable(input logic [addr_width-1:0] addr);
        return (addr != '0) && ({1'b0, addr} < depth_lim);
    endfunction

    // Reset is deliberately not part of write_hit: the bypass forwards a
    // reset-cycle write for that one cycle, and the reset branch of the
    // storage process still drops it at the edge.
    assign write_hit   = WriteEnable && addr_usable(WriteAddr);
    assign read1_valid = addr_usable(ReadAddr1);
    assign read2_valid = addr_usable(ReadAddr2);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else if (write_hit) begin
            mem[WriteAddr] <= WriteData;
        end
    end

    // Both ports share the same selection rule so they always agree when
    // they address the same entry, bypass case included.
    always_comb begin
        ReadData1 = '0;
        if (read1_valid) begin
            if ((bypass != 0) && write_hit && (WriteAddr == ReadAddr1)) begin
                ReadData1 = WriteData;
            end else begin
                ReadData1 = mem[ReadAddr1];
            end
        end
    end

    always_comb begin
        ReadData2 = '0;
        if (read2_valid) begin
            if ((bypass != 0) && write_hit && (WriteAddr == ReadAddr2)) begin
                ReadData2 = WriteData;
            end else begin
                ReadData2 = mem[ReadAddr2];
            end
        end
    end

endmodule
